// File: rtl/sram_w16_ctrl_pkg.sv
// Shared constants and the per-cycle SRAM access type for the 16-address SRAM FIFO controller.
package sram_ctrl_pkg;
    localparam int DATA_W     = 128;
    localparam int ADDR_W     = 4;
    localparam int DEPTH      = 8;
    localparam int OBUF_DEPTH = 2;
    localparam int PTR_W      = 3;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        ACC_IDLE = 2'd0,
        ACC_WR   = 2'd1,
        ACC_RD   = 2'd2
    } acc_e;
endpackage

// File: rtl/sram_w16_ctrl_if.sv
// Stream and SRAM macro signals of the FIFO controller; master = controller, slave = its environment.
interface sram_w16_ctrl_if;
    import sram_ctrl_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [3:0]        occupancy;
    logic              sram_cen;
    logic              sram_wen;
    logic [ADDR_W-1:0] sram_a;
    logic [DATA_W-1:0] sram_d;
    logic [DATA_W-1:0] sram_q;

    modport master (
        input  in_valid, in_data, out_ready, sram_q,
        output in_ready, out_valid, out_data, occupancy,
        output sram_cen, sram_wen, sram_a, sram_d
    );

    modport slave (
        output in_valid, in_data, out_ready, sram_q,
        input  in_ready, out_valid, out_data, occupancy,
        input  sram_cen, sram_wen, sram_a, sram_d
    );
endinterface

// File: rtl/sram_w16_ctrl_rd_skid.sv
// Two-entry output buffer catching SRAM read returns; head entry is held until popped.
module sram_rd_skid
    import sram_ctrl_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              clr_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [1:0]        cnt_o,
    output logic [DATA_W-1:0] head_o
);
    logic [DATA_W-1:0] mem_q [OBUF_DEPTH];
    logic              rd_idx_q, rd_idx_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              wr_idx;
    logic              do_pop;
    logic              do_push;

    always_comb begin
        do_pop   = pop_i && (cnt_q != 2'd0) && !clr_i;
        do_push  = push_i && !clr_i;
        // Free slot sits right behind the head; with two entries that is head ^ count[0].
        wr_idx   = rd_idx_q ^ cnt_q[0];
        rd_idx_d = rd_idx_q ^ do_pop;
        cnt_d    = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
        if (clr_i) begin
            rd_idx_d = 1'b0;
            cnt_d    = 2'd0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_idx_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            rd_idx_q <= rd_idx_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem_q[wr_idx] <= push_data_i;
        end
    end

    assign cnt_o  = cnt_q;
    assign head_o = mem_q[rd_idx_q];
endmodule

// File: rtl/sram_w16_ctrl.sv
// Streaming FIFO on a single-port SRAM: arbitrates one write or read per cycle, alternating when both want it.
//
//  access   | meaning
//  ACC_IDLE | no SRAM access this cycle, address bus holds
//  ACC_WR   | input word written at wr_ptr
//  ACC_RD   | word read at rd_ptr, returns on sram_q next cycle
module sram_w16_ctrl
    import sram_ctrl_pkg::*;
(
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            clr,
    sram_w16_ctrl_if.master bus
);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  sram_cnt_q, sram_cnt_d;
    logic              rd_inflight_q, rd_inflight_d;
    logic              last_was_rd_q, last_was_rd_d;
    logic [ADDR_W-1:0] sram_a_q, sram_a_d;
    logic              run_q;

    acc_e              acc;
    logic              rd_req;
    logic              wr_req;
    logic [2:0]        rd_pending;
    logic [1:0]        obuf_cnt;
    logic [DATA_W-1:0] obuf_head;
    logic              obuf_push;

    // run_q keeps the input side closed until the first edge after reset release.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            sram_cnt_q    <= '0;
            rd_inflight_q <= 1'b0;
            last_was_rd_q <= 1'b0;
            sram_a_q      <= '0;
            run_q         <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            sram_cnt_q    <= sram_cnt_d;
            rd_inflight_q <= rd_inflight_d;
            last_was_rd_q <= last_was_rd_d;
            sram_a_q      <= sram_a_d;
            run_q         <= 1'b1;
        end
    end

    always_comb begin
        // Reads are throttled by buffer room including the read still in flight, so no out_ready path.
        rd_pending = {1'b0, obuf_cnt} + {2'b00, rd_inflight_q};
        rd_req     = (sram_cnt_q != '0) && (rd_pending < 3'(OBUF_DEPTH)) && !clr;
        wr_req     = run_q && bus.in_valid && (sram_cnt_q < FULL_CNT) && !clr;

        acc = ACC_IDLE;
        if (wr_req && rd_req) begin
            acc = last_was_rd_q ? ACC_WR : ACC_RD;
        end else if (wr_req) begin
            acc = ACC_WR;
        end else if (rd_req) begin
            acc = ACC_RD;
        end

        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        sram_cnt_d    = sram_cnt_q;
        rd_inflight_d = 1'b0;
        last_was_rd_d = last_was_rd_q;
        sram_a_d      = sram_a_q;

        unique case (acc)
            ACC_WR: begin
                wr_ptr_d      = wr_ptr_q + 3'd1;
                sram_cnt_d    = sram_cnt_q + 4'd1;
                last_was_rd_d = 1'b0;
                sram_a_d      = {1'b0, wr_ptr_q};
            end
            ACC_RD: begin
                rd_ptr_d      = rd_ptr_q + 3'd1;
                sram_cnt_d    = sram_cnt_q - 4'd1;
                rd_inflight_d = 1'b1;
                last_was_rd_d = 1'b1;
                sram_a_d      = {1'b0, rd_ptr_q};
            end
            default: ;
        endcase

        if (clr) begin
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            sram_cnt_d    = '0;
            rd_inflight_d = 1'b0;
        end
    end

    always_comb begin
        bus.sram_cen  = (acc == ACC_IDLE);
        bus.sram_wen  = (acc != ACC_WR);
        bus.sram_a    = sram_a_d;
        bus.sram_d    = bus.in_data;
        bus.in_ready  = run_q && (sram_cnt_q < FULL_CNT) && !clr && !(rd_req && !last_was_rd_q);
        bus.out_valid = (obuf_cnt != 2'd0);
        bus.out_data  = obuf_head;
        bus.occupancy = sram_cnt_q + {3'b000, rd_inflight_q} + {2'b00, obuf_cnt};
    end

    assign obuf_push = rd_inflight_q && !clr;

    sram_rd_skid u_skid (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .clr_i       (clr),
        .push_i      (obuf_push),
        .push_data_i (bus.sram_q),
        .pop_i       (bus.out_ready),
        .cnt_o       (obuf_cnt),
        .head_o      (obuf_head)
    );
endmodule
